// File: rtl/exe_stack_unit.sv
// Hardware LIFO for the EXE stage: pushes operand values, returns the top entry
// one cycle after a pop, and reports occupancy plus sticky overflow/underflow flags.
module exe_stack_unit #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushEn,
  input  logic             popEn,
  input  logic [WIDTH-1:0] pushData,
  input  logic             clrErr,
  output logic [WIDTH-1:0] popData,
  output logic             popValid,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_sp;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_pop_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic [PTR_W:0]   w_sp_m1;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_free_idx;
  logic             w_mem_we;
  logic [PTR_W-1:0] w_mem_idx;
  logic [WIDTH-1:0] w_top_data;

  assign w_full     = (r_sp == FULL_CNT);
  assign w_empty    = (r_sp == '0);
  assign w_sp_m1    = r_sp - ONE;
  assign w_top_idx  = w_sp_m1[PTR_W-1:0];
  assign w_free_idx = r_sp[PTR_W-1:0];
  assign w_top_data = r_mem[w_top_idx];

  // Push-only writes the free slot; push+pop on a non-empty stack overwrites the top.
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_idx = w_free_idx;
    if (pushEn && !popEn && !w_full) begin
      w_mem_we  = 1'b1;
      w_mem_idx = w_free_idx;
    end else if (pushEn && popEn && !w_empty) begin
      w_mem_we  = 1'b1;
      w_mem_idx = w_top_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_mem_we) begin
      r_mem[w_mem_idx] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sp        <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      // Clear first so an error event later in this block takes priority.
      if (clrErr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      unique case ({pushEn, popEn})
        2'b10: begin
          if (w_full) r_overflow <= 1'b1;
          else        r_sp       <= r_sp + ONE;
        end
        2'b01: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_pop_data  <= w_top_data;
            r_pop_valid <= 1'b1;
            r_sp        <= w_sp_m1;
          end
        end
        2'b11: begin
          r_pop_data  <= w_empty ? pushData : w_top_data;
          r_pop_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign popData   = r_pop_data;
  assign popValid  = r_pop_valid;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_sp;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_exe_stack_unit.sv
// Directed scenario bench for exe_stack_unit with hand-computed expectations.
module tb_exe_stack_unit;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pushEn;
  logic             popEn;
  logic [WIDTH-1:0] pushData;
  logic             clrErr;
  logic [WIDTH-1:0] popData;
  logic             popValid;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  exe_stack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .pushEn(pushEn), .popEn(popEn), .pushData(pushData),
    .clrErr(clrErr), .popData(popData), .popValid(popValid), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic pop, input logic [WIDTH-1:0] d,
                       input logic clr);
    pushEn = push; popEn = pop; pushData = d; clrErr = clr;
    step();
    pushEn = 1'b0; popEn = 1'b0; clrErr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pushEn = 1'b0; popEn = 1'b0; pushData = '0; clrErr = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (popValid !== 1'b0) begin bad++; $display("FAIL reset_popValid got=%b exp=0", popValid); end
    total++; if (popData !== 32'h0) begin bad++; $display("FAIL reset_popData got=%h exp=0", popData); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_lifo();
    logic [WIDTH-1:0] exp_d [3];
    exp_d[0] = 32'h33; exp_d[1] = 32'h22; exp_d[2] = 32'h11;
    drive(1'b1, 1'b0, 32'h11, 1'b0);
    drive(1'b1, 1'b0, 32'h22, 1'b0);
    drive(1'b1, 1'b0, 32'h33, 1'b0);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL lifo_count3 got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, '0, 1'b0);
      total++; if (popData !== exp_d[i] || popValid !== 1'b1) begin bad++; $display("FAIL lifo_pop%0d got=%h/%b exp=%h/1", i, popData, popValid, exp_d[i]); end
      total++; if (count !== 5'(2 - i)) begin bad++; $display("FAIL lifo_cnt%0d got=%0d exp=%0d", i, count, 2 - i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL lifo_empty got=%b exp=1", empty); end
    step();
    total++; if (popValid !== 1'b0 || popData !== 32'h11) begin bad++; $display("FAIL lifo_idle_hold got=%h/%b exp=11/0", popData, popValid); end
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, WIDTH'(i), 1'b0);
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL full_set got=%b/%0d exp=1/16", full, count); end
    drive(1'b1, 1'b0, 32'hDEAD, 1'b0);
    total++; if (count !== 5'd16 || overflow !== 1'b1) begin bad++; $display("FAIL overflow_push got=%0d/%b exp=16/1", count, overflow); end
    step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    drive(1'b0, 1'b1, '0, 1'b0);
    total++; if (popData !== 32'd16 || full !== 1'b0 || count !== 5'd15) begin bad++; $display("FAIL full_pop got=%h/%b/%0d exp=10/0/15", popData, full, count); end
    drive(1'b0, 1'b0, '0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_clr got=%b exp=0", overflow); end
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b1, '0, 1'b0);
    total++; if (popData !== 32'd1 || count !== 5'd0) begin bad++; $display("FAIL drain got=%h/%0d exp=1/0", popData, count); end
  endtask

  task automatic test_underflow();
    step();
    drive(1'b0, 1'b1, '0, 1'b0);
    total++; if (popValid !== 1'b0 || popData !== 32'd1) begin bad++; $display("FAIL uf_pop got=%h/%b exp=1/0", popData, popValid); end
    total++; if (underflow !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL uf_flag got=%b/%0d exp=1/0", underflow, count); end
    drive(1'b0, 1'b1, '0, 1'b1);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_clr_collide got=%b exp=1", underflow); end
    drive(1'b0, 1'b0, '0, 1'b1);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clr got=%b exp=0", underflow); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b0, 32'hAA, 1'b0);
    drive(1'b1, 1'b1, 32'hBB, 1'b0);
    total++; if (popData !== 32'hAA || popValid !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL replace got=%h/%b/%0d exp=aa/1/1", popData, popValid, count); end
    drive(1'b0, 1'b1, '0, 1'b0);
    total++; if (popData !== 32'hBB || count !== 5'd0) begin bad++; $display("FAIL replace_follow got=%h/%0d exp=bb/0", popData, count); end
    drive(1'b1, 1'b1, 32'h55, 1'b0);
    total++; if (popData !== 32'h55 || popValid !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL bypass got=%h/%b/%0d exp=55/1/0", popData, popValid, count); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL bypass_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, WIDTH'(32'h100 + i), 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0);
    total++; if (popData !== 32'h104 || count !== 5'd4 || underflow !== 1'b1) begin bad++; $display("FAIL pre_reset got=%h/%0d/%b exp=104/4/1", popData, count, underflow); end
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h777, 1'b0);
    rst = 1'b1;
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL midrst_count got=%0d/%b exp=0/1", count, empty); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0 || popValid !== 1'b0 || popData !== 32'h0) begin bad++; $display("FAIL midrst_state got=%b%b/%b/%h exp=00/0/0", overflow, underflow, popValid, popData); end
    drive(1'b0, 1'b1, '0, 1'b0);
    total++; if (underflow !== 1'b1 || popValid !== 1'b0) begin bad++; $display("FAIL midrst_push_ignored got=%b/%b exp=1/0", underflow, popValid); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_full_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
